// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: request payload and source id.
package wb_pkg;

  localparam int unsigned REG_AW       = 5;
  localparam int unsigned XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [REG_AW-1:0]       addr;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

  typedef logic src_id_t;

  localparam src_id_t SRC0 = 1'b0;
  localparam src_id_t SRC1 = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; also exposes every slot's
// valid bit and destination address so the owner can do hazard compares.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         req_t = wb_req_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  req_t                         push_req,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output req_t                         head,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] entry_addr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  req_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_req;
  end

  // A slot is live when its distance from the read index is below occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [AW-1:0] offset;
    assign offset         = AW'(i) - rd_ptr_q[AW-1:0];
    assign entry_valid[i] = {1'b0, offset} < count;
    assign entry_addr[i]  = mem_q[i].addr;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between the execute and load writeback
// sources: per-source FIFOs, round-robin drain into a registered write stage.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [REG_AW-1:0] s0_addr,
  input  logic [XLEN-1:0]   s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [REG_AW-1:0] s1_addr,
  input  logic [XLEN-1:0]   s1_data,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data,
  input  logic [REG_AW-1:0] chk0_addr,
  input  logic [REG_AW-1:0] chk1_addr,
  output logic              chk0_pending,
  output logic              chk1_pending
);

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } req_t;

  logic                         full0, empty0, full1, empty1;
  logic                         push0, push1;
  logic                         grant0, grant1;
  req_t                         req0, req1, head0, head1;
  logic [DEPTH-1:0]             ev0, ev1;
  logic [DEPTH-1:0][REG_AW-1:0] ea0, ea1;

  src_id_t           last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;

  // Ready reflects current occupancy only; x0 writes handshake but are dropped.
  assign s0_ready = !rst && !full0;
  assign s1_ready = !rst && !full1;
  assign push0    = s0_valid && s0_ready && (s0_addr != '0);
  assign push1    = s1_valid && s1_ready && (s1_addr != '0);
  assign req0     = '{addr: s0_addr, data: s0_data};
  assign req1     = '{addr: s1_addr, data: s1_data};

  wb_fifo #(.DEPTH(DEPTH), .req_t(req_t)) u_fifo0 (
    .clk         (clk),
    .rst         (rst),
    .push        (push0),
    .push_req    (req0),
    .pop         (grant0),
    .full        (full0),
    .empty       (empty0),
    .head        (head0),
    .entry_valid (ev0),
    .entry_addr  (ea0)
  );

  wb_fifo #(.DEPTH(DEPTH), .req_t(req_t)) u_fifo1 (
    .clk         (clk),
    .rst         (rst),
    .push        (push1),
    .push_req    (req1),
    .pop         (grant1),
    .full        (full1),
    .empty       (empty1),
    .head        (head1),
    .entry_valid (ev1),
    .entry_addr  (ea1)
  );

  // Round-robin: on contention the source that did not win last time goes.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!empty0 && (empty1 || last_grant_q == SRC1)) grant0 = 1'b1;
    else if (!empty1)                                 grant1 = 1'b1;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (grant0) begin
      last_grant_d = SRC0;
      wr_en_d      = 1'b1;
      wr_addr_d    = head0.addr;
      wr_data_d    = head0.data;
    end else if (grant1) begin
      last_grant_d = SRC1;
      wr_en_d      = 1'b1;
      wr_addr_d    = head1.addr;
      wr_data_d    = head1.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;

  // A write is in flight while queued in either FIFO or sitting in the write stage.
  always_comb begin
    chk0_pending = 1'b0;
    chk1_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((ev0[i] && ea0[i] == chk0_addr) || (ev1[i] && ea1[i] == chk0_addr)) chk0_pending = 1'b1;
      if ((ev0[i] && ea0[i] == chk1_addr) || (ev1[i] && ea1[i] == chk1_addr)) chk1_pending = 1'b1;
    end
    if (wr_en_q && wr_addr_q == chk0_addr) chk0_pending = 1'b1;
    if (wr_en_q && wr_addr_q == chk1_addr) chk1_pending = 1'b1;
    if (chk0_addr == '0) chk0_pending = 1'b0;
    if (chk1_addr == '0) chk1_pending = 1'b0;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the writeback port.
module tb_wb_port_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s0_valid = 1'b0, s1_valid = 1'b0;
  logic            s0_ready, s1_ready;
  logic [4:0]      s0_addr = '0, s1_addr = '0;
  logic [XLEN-1:0] s0_data = '0, s1_data = '0;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [4:0]      chk0_addr = '0, chk1_addr = '0;
  logic            chk0_pending, chk1_pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } mreq_t;

  mreq_t           mq0[$];
  mreq_t           mq1[$];
  bit              m_lg   = 1'b1;
  bit              m_en   = 1'b0;
  logic [4:0]      m_addr = '0;
  logic [XLEN-1:0] m_data = '0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s0_addr      (s0_addr),
    .s0_data      (s0_data),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .s1_addr      (s1_addr),
    .s1_data      (s1_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .chk0_addr    (chk0_addr),
    .chk1_addr    (chk1_addr),
    .chk0_pending (chk0_pending),
    .chk1_pending (chk1_pending)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit m_ready(input int n);
    if (rst) return 1'b0;
    return (n == 0) ? (mq0.size() < int'(DEPTH)) : (mq1.size() < int'(DEPTH));
  endfunction

  function automatic bit m_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq0[i]) if (mq0[i].a == a) return 1'b1;
    foreach (mq1[i]) if (mq1[i].a == a) return 1'b1;
    return m_en && (m_addr == a);
  endfunction

  // One clock edge; the model applies the same edge's handshakes and grant.
  task automatic tick();
    bit    a0, a1;
    int    g;
    mreq_t r;
    @(posedge clk);
    if (rst) begin
      mq0.delete();
      mq1.delete();
      m_lg   = 1'b1;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      a0 = s0_valid && (mq0.size() < int'(DEPTH));
      a1 = s1_valid && (mq1.size() < int'(DEPTH));
      g  = -1;
      if (mq0.size() > 0 && mq1.size() > 0) g = m_lg ? 0 : 1;
      else if (mq0.size() > 0)              g = 0;
      else if (mq1.size() > 0)              g = 1;
      m_en = (g >= 0);
      if (g == 0) begin r = mq0.pop_front(); m_addr = r.a; m_data = r.d; m_lg = 1'b0; end
      if (g == 1) begin r = mq1.pop_front(); m_addr = r.a; m_data = r.d; m_lg = 1'b1; end
      if (a0 && s0_addr != 5'd0) mq0.push_back('{a: s0_addr, d: s0_data});
      if (a1 && s1_addr != 5'd0) mq1.push_back('{a: s1_addr, d: s1_data});
    end
    #1;
  endtask

  task automatic idle();
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
  endtask

  task automatic send0(input logic [4:0] a, input logic [XLEN-1:0] d);
    s0_valid = 1'b1; s0_addr = a; s0_data = d;
  endtask

  task automatic send1(input logic [4:0] a, input logic [XLEN-1:0] d);
    s1_valid = 1'b1; s1_addr = a; s1_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", rf_wr_en); end
    checks++; if (rf_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rf_wr_addr); end
    checks++; if (rf_wr_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", rf_wr_data); end
    checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0)
      begin errors++; $display("FAIL reset_ready_low got=%b%b exp=00", s0_ready, s1_ready); end
    rst = 1'b0;
    #1;
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready_high got=%b%b exp=11", s0_ready, s1_ready); end
  endtask

  task automatic test_single();
    int nw = 0;
    do_reset();
    chk0_addr = 5'd5;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) send0(5'd5, 32'h11); else idle();
      #1;
      checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL single_s1_ready c=%0d got=%b exp=1", c, s1_ready); end
      checks++; if (rf_wr_en !== (c == 2)) begin errors++; $display("FAIL single_en c=%0d got=%b exp=%b", c, rf_wr_en, (c == 2)); end
      checks++; if (chk0_pending !== (c == 1 || c == 2))
        begin errors++; $display("FAIL single_pending c=%0d got=%b exp=%b", c, chk0_pending, (c == 1 || c == 2)); end
      if (rf_wr_en === 1'b1) begin
        nw++;
        checks++; if (rf_wr_addr !== 5'd5 || rf_wr_data !== 32'h11)
          begin errors++; $display("FAIL single_payload got=%0d/%h exp=5/11", rf_wr_addr, rf_wr_data); end
      end
      tick();
    end
    checks++; if (nw != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", nw); end
  endtask

  task automatic test_contention();
    logic [4:0] l0 [3] = '{5'd1, 5'd2, 5'd3};
    logic [4:0] l1 [3] = '{5'd10, 5'd11, 5'd12};
    logic [4:0] exp_order [6] = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12};
    logic [4:0] seen[$];
    int i0 = 0, i1 = 0, gaps = 0;
    bit started = 1'b0, h0, h1;
    do_reset();
    for (int c = 0; c < 20 && seen.size() < 6; c++) begin
      if (i0 < 3) send0(l0[i0], 32'(32'h100 + i0)); else begin s0_valid = 1'b0; end
      if (i1 < 3) send1(l1[i1], 32'(32'h200 + i1)); else begin s1_valid = 1'b0; end
      #1;
      if (rf_wr_en === 1'b1) begin seen.push_back(rf_wr_addr); started = 1'b1; end
      else if (started) gaps++;
      h0 = s0_valid && s0_ready;
      h1 = s1_valid && s1_ready;
      tick();
      if (h0) i0++;
      if (h1) i1++;
    end
    idle();
    checks++; if (seen.size() != 6) begin errors++; $display("FAIL contention_count got=%0d exp=6", seen.size()); end
    for (int k = 0; k < 6 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== exp_order[k])
        begin errors++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d", k, seen[k], exp_order[k]); end
    end
    checks++; if (gaps != 0) begin errors++; $display("FAIL contention_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_backpressure();
    logic [4:0] seen0[$];
    logic [4:0] seen1[$];
    int i0 = 0, i1 = 0, first_drop = -1;
    bit h0, h1;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (i0 < 8) send0(5'(20 + i0), 32'(32'h2000 + i0)); else begin s0_valid = 1'b0; end
      if (i1 < 4) send1(5'(16 + i1), 32'(32'h1000 + i1)); else begin s1_valid = 1'b0; end
      #1;
      checks++; if (s1_ready !== m_ready(1))
        begin errors++; $display("FAIL bp_ready1 c=%0d got=%b exp=%b", c, s1_ready, m_ready(1)); end
      if (s1_valid && !s1_ready && first_drop < 0) first_drop = i1;
      if (rf_wr_en === 1'b1) begin
        if (rf_wr_addr >= 5'd20) seen0.push_back(rf_wr_addr); else seen1.push_back(rf_wr_addr);
      end
      h0 = s0_valid && s0_ready;
      h1 = s1_valid && s1_ready;
      tick();
      if (h0) i0++;
      if (h1) i1++;
      if (seen0.size() >= 8 && seen1.size() >= 4) break;
    end
    idle();
    checks++; if (first_drop != int'(DEPTH)) begin errors++; $display("FAIL bp_drop_point got=%0d exp=%0d", first_drop, DEPTH); end
    checks++; if (seen1.size() != 4) begin errors++; $display("FAIL bp_s1_count got=%0d exp=4", seen1.size()); end
    checks++; if (seen0.size() != 8) begin errors++; $display("FAIL bp_s0_count got=%0d exp=8", seen0.size()); end
    foreach (seen1[k]) begin
      checks++; if (seen1[k] !== 5'(16 + k)) begin errors++; $display("FAIL bp_s1_order idx=%0d got=%0d exp=%0d", k, seen1[k], 16 + k); end
    end
    foreach (seen0[k]) begin
      checks++; if (seen0[k] !== 5'(20 + k)) begin errors++; $display("FAIL bp_s0_order idx=%0d got=%0d exp=%0d", k, seen0[k], 20 + k); end
    end
  endtask

  task automatic test_x0();
    int nw = 0;
    logic [4:0]      wa = '0;
    logic [XLEN-1:0] wd = '0;
    do_reset();
    chk0_addr = 5'd0;
    chk1_addr = 5'd3;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) send0(5'd0, 32'hDEAD);
      else if (c == 1) send0(5'd3, 32'h7);
      else idle();
      #1;
      if (c < 2) begin
        checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL x0_ready c=%0d got=%b exp=1", c, s0_ready); end
      end
      checks++; if (chk0_pending !== 1'b0) begin errors++; $display("FAIL x0_pending c=%0d got=%b exp=0", c, chk0_pending); end
      if (c == 2) begin
        checks++; if (chk1_pending !== 1'b1) begin errors++; $display("FAIL x0_addr3_pending got=%b exp=1", chk1_pending); end
      end
      if (rf_wr_en === 1'b1) begin nw++; wa = rf_wr_addr; wd = rf_wr_data; end
      tick();
    end
    checks++; if (nw != 1) begin errors++; $display("FAIL x0_write_count got=%0d exp=1", nw); end
    checks++; if (wa !== 5'd3 || wd !== 32'h7) begin errors++; $display("FAIL x0_payload got=%0d/%h exp=3/7", wa, wd); end
  endtask

  task automatic test_hazard();
    bit exp9 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit exp4 [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    chk0_addr = 5'd9;
    chk1_addr = 5'd4;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin send0(5'd4, 32'h44); send1(5'd9, 32'h99); end else idle();
      #1;
      checks++; if (chk0_pending !== exp9[c]) begin errors++; $display("FAIL hazard_pend9 c=%0d got=%b exp=%b", c, chk0_pending, exp9[c]); end
      checks++; if (chk1_pending !== exp4[c]) begin errors++; $display("FAIL hazard_pend4 c=%0d got=%b exp=%b", c, chk1_pending, exp4[c]); end
      checks++; if ((rf_wr_en === 1'b1 && rf_wr_addr === 5'd9) !== (c == 3))
        begin errors++; $display("FAIL hazard_write9 c=%0d got=%b/%0d exp_at=3", c, rf_wr_en, rf_wr_addr); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] last0 = '0, last1 = '0;
    logic [4:0] seen[$];
    int i0 = 0, i1 = 0;
    bit h0, h1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      send0(5'(1 + i0), 32'(c));
      send1(5'(17 + i1), 32'(c + 100));
      #1;
      h0 = s0_valid && s0_ready;
      h1 = s1_valid && s1_ready;
      tick();
      if (h0) begin last0 = 5'(1 + i0); i0++; end
      if (h1) begin last1 = 5'(17 + i1); i1++; end
    end
    chk0_addr = last0;
    chk1_addr = last1;
    #1;
    checks++; if (chk0_pending !== 1'b1 || chk1_pending !== 1'b1)
      begin errors++; $display("FAIL mid_pending_before got=%b%b exp=11", chk0_pending, chk1_pending); end
    rst = 1'b1;
    #1;
    checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0)
      begin errors++; $display("FAIL mid_ready_in_rst got=%b%b exp=00", s0_ready, s1_ready); end
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== '0)
      begin errors++; $display("FAIL mid_out_cleared got=%b/%0d/%h exp=0/0/0", rf_wr_en, rf_wr_addr, rf_wr_data); end
    checks++; if (chk0_pending !== 1'b0 || chk1_pending !== 1'b0)
      begin errors++; $display("FAIL mid_pending_after got=%b%b exp=00", chk0_pending, chk1_pending); end
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1)
      begin errors++; $display("FAIL mid_ready_after got=%b%b exp=11", s0_ready, s1_ready); end
    send0(5'd7, 32'h77);
    send1(5'd8, 32'h88);
    tick();
    idle();
    for (int c = 0; c < 6; c++) begin
      if (rf_wr_en === 1'b1) seen.push_back(rf_wr_addr);
      tick();
    end
    checks++; if (seen.size() != 2) begin errors++; $display("FAIL mid_write_count got=%0d exp=2", seen.size()); end
    if (seen.size() == 2) begin
      checks++; if (seen[0] !== 5'd7 || seen[1] !== 5'd8)
        begin errors++; $display("FAIL mid_first_grant got=%0d,%0d exp=7,8", seen[0], seen[1]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      s0_valid = ($urandom_range(0, 2) != 0);
      s1_valid = ($urandom_range(0, 2) != 0);
      s0_addr  = 5'($urandom_range(0, 7));
      s1_addr  = 5'($urandom_range(0, 7));
      s0_data  = 32'($urandom);
      s1_data  = 32'($urandom);
      chk0_addr = 5'($urandom_range(0, 7));
      chk1_addr = 5'($urandom_range(0, 7));
      #1;
      checks++; if (s0_ready !== m_ready(0) || s1_ready !== m_ready(1))
        begin errors++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, s0_ready, s1_ready, m_ready(0), m_ready(1)); end
      checks++; if (chk0_pending !== m_pending(chk0_addr) || chk1_pending !== m_pending(chk1_addr))
        begin errors++; $display("FAIL rand_pending c=%0d got=%b%b exp=%b%b", c, chk0_pending, chk1_pending,
                                 m_pending(chk0_addr), m_pending(chk1_addr)); end
      tick();
      checks++; if (rf_wr_en !== m_en || rf_wr_addr !== m_addr || rf_wr_data !== m_data)
        begin errors++; $display("FAIL rand_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_wr_en, rf_wr_addr, rf_wr_data,
                                 m_en, m_addr, m_data); end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_x0();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: source 0 (ALU/execute result) and source 1 (load unit).
- Each source has a small FIFO. A round-robin arbiter drains the FIFO heads into a registered write stage that drives the register file's reg_wr, wr_addr and wr_data.
- Also reports whether a register has a write still in flight, so issue logic can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of the writeback value.
- DEPTH, 2, entries per source FIFO; a power of two, 2 or greater.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- s0_valid  in  1  source 0 has a writeback request.
- s0_ready  out  1  source 0 request is accepted this cycle.
- s0_addr  in  5  source 0 destination register.
- s0_data  in  XLEN  source 0 writeback value.
- s1_valid  in  1  source 1 has a writeback request.
- s1_ready  out  1  source 1 request is accepted this cycle.
- s1_addr  in  5  source 1 destination register.
- s1_data  in  XLEN  source 1 writeback value.
- rf_wr_en  out  1  register file write enable, registered.
- rf_wr_addr  out  5  register file write address, registered.
- rf_wr_data  out  XLEN  register file write data, registered.
- chk0_addr  in  5  hazard query address 0.
- chk1_addr  in  5  hazard query address 1.
- chk0_pending  out  1  chk0_addr has an undelivered write.
- chk1_pending  out  1  chk1_addr has an undelivered write.

Behaviour:
- Handshake:
  - A transfer occurs on a posedge where sN_valid and sN_ready are both 1.
  - sN_ready = !fifoN_full, decided combinationally from current occupancy only. There is no pop-through: a full FIFO holds ready low even in a cycle where it pops.
  - sN_valid is independent of ready.
- x0 writes: a request with sN_addr == 0 completes the handshake normally but is not written into the FIFO and never produces rf_wr_en.
- Arbitration, every cycle:
  - Candidates are the non-empty FIFO heads.
  - If exactly one is non-empty, it is granted.
  - If both are non-empty, the source other than last_grant is granted; last_grant updates only on an actual grant.
  - The granted head is popped at the posedge and loaded into the output register.
- Output register:
  - On a grant, rf_wr_en=1 and rf_wr_addr/rf_wr_data take the head's address and data.
  - With no grant, rf_wr_en=0 and addr/data hold their previous values.
  - rf_wr_en is high for exactly one cycle per delivered request.
- Latency and throughput:
  - A request accepted at posedge N into an empty FIFO with no contention gives rf_wr_en high in the cycle following posedge N+1 (two-cycle latency).
  - Sustained throughput is one write per cycle total.
- Ordering:
  - Per-source order is preserved.
  - No ordering is guaranteed between sources. Issue logic must use the pending outputs to avoid WAW hazards across sources.
- Pending check, combinational:
  - chkK_pending = 1 when chkK_addr != 0 and it matches a valid entry in either FIFO, or the output register while rf_wr_en=1.
  - An address being accepted in the current cycle is not included.
- Reset (rst=1 at a posedge):
  - FIFOs are emptied and pointers zeroed; in-flight requests are discarded.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0.
  - last_grant=1, so source 0 wins the first contention.
  - During reset, sN_ready=0 and no handshake completes.
- Simultaneous push and pop on the same FIFO (non-full): both take effect and occupancy is unchanged.
- Pointer wrap: pointers are log2(DEPTH)+1 bits; full/empty are decided from the MSB compare.

Decomposition:
- Package wb_pkg:
  - REG_AW=5 and XLEN default.
  - typedef wb_req_t as a packed struct {addr[4:0], data[XLEN-1:0]}.
  - typedef src_id_t (1 bit).
- Sub-module wb_fifo:
  - Synchronous DEPTH-entry FIFO of wb_req_t.
  - Ports: push, pop, full, empty, head, plus an entry-valid/entry-addr vector exported for the pending compare.
  - Instantiated twice.
- The arbiter, output register and pending compare live in the top level.

Test Plan:
- Single source: s0 sends (addr 5, data 0x11) at cycle 0 -> rf_wr_en=1 with addr 5, data 0x11 exactly in cycle 2; s1_ready stays 1 throughout.
- Contention after reset: both sources push every cycle, s0 sending addrs 1,2,3 and s1 sending 10,11,12 -> write order 1,10,2,11,3,12 with rf_wr_en continuously high.
- Backpressure: s1 valid for 4 consecutive cycles while s0 keeps FIFO0 non-empty -> s1_ready drops after DEPTH accepts; no request lost or duplicated; per-source order preserved.
- x0 drop: s0 sends (addr 0, data 0xDEAD) followed by (addr 3, data 0x7) -> both handshakes complete; only addr 3 is written; chk0_addr=0 reads pending=0.
- Hazard: s1 sends addr 9 with s0 contending; chk0_addr=9 -> pending=1 from the cycle after acceptance through the cycle rf_wr_en drives addr 9, then 0.
- Reset mid-operation: both FIFOs full, assert rst one cycle -> the next cycle has rf_wr_en=0, both pending=0, both ready=1 after rst deasserts, and the first contention grants s0.
